// File: rtl/oh_fifo_sync_ctrl.sv
// oh_fifo_sync_ctrl: single-clock FIFO controller for a dual-port RAM with a
// registered read port; the RAM output register doubles as the FWFT stage.
module oh_fifo_sync_ctrl #(
    parameter int DW        = 104,
    parameter int DEPTH     = 32,
    parameter int AW        = $clog2(DEPTH),
    parameter int PROG_FULL = DEPTH - 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          prog_full,
    input  logic          rd_en,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_wr_wem,
    output logic [DW-1:0] mem_wr_din,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_dout
);

    localparam int          PTR_W     = AW + 1;
    localparam logic [AW:0] DEPTH_C   = PTR_W'(DEPTH);
    localparam logic [AW:0] PROG_FULL_C = PTR_W'(PROG_FULL);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        out_valid_q, out_valid_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;

    logic [AW:0] ram_count;
    logic        do_wr;
    logic        fetch;

    // Pointers carry one extra wrap bit so DEPTH entries and zero entries differ.
    assign ram_count = wr_ptr_q - rd_ptr_q;

    always_comb begin
        do_wr       = wr_en & ~full;
        fetch       = (ram_count != '0) & (~out_valid_q | rd_en);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        overflow_d  = wr_en & full;
        underflow_d = rd_en & empty;

        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (fetch) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // A fetch refills the output register in the same edge that a pop empties it.
        if (fetch) begin
            out_valid_d = 1'b1;
        end else if (rd_en) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign full      = (ram_count == DEPTH_C);
    assign prog_full = (ram_count >= PROG_FULL_C);
    assign empty     = ~out_valid_q;
    assign count     = ram_count + {{AW{1'b0}}, out_valid_q};
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign dout      = mem_rd_dout;

    assign mem_wr_en   = do_wr;
    assign mem_wr_addr = wr_ptr_q[AW-1:0];
    assign mem_wr_wem  = '1;
    assign mem_wr_din  = din;
    assign mem_rd_en   = fetch;
    assign mem_rd_addr = rd_ptr_q[AW-1:0];

endmodule
